// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: stores to TX_ADDR queue bytes in a
// 4-entry FIFO that an 8N1 serializer drains back-to-back onto tx.
//
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous active-high reset
//   memwrite   processor store strobe
//   dataadr    processor store address (full 32-bit compare)
//   writedata  processor store data, bits [7:0] used
//   tx         registered serial line, idle high
//   busy       FSM active or FIFO non-empty
//   fifo_count queued bytes, 0..4
//   full       fifo_count == 4
//   overflow   sticky: a store was dropped on a full FIFO
module mmio_uart_tx #(
   parameter int          CLKS_PER_BIT = 4,
   parameter logic [31:0] TX_ADDR      = 32'h0000_00FC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic        tx,
   output logic        busy,
   output logic [2:0]  fifo_count,
   output logic        full,
   output logic        overflow
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t      state, state_n;
   logic [7:0]  mem [4];
   logic [1:0]  rptr, wptr;
   logic [2:0]  count;
   logic [7:0]  cnt, cnt_n;
   logic [2:0]  bitn, bitn_n;
   logic [7:0]  shift, shift_n;
   logic        tx_n;
   logic        push, pop, wr, empty, last;

   assign push       = memwrite && (dataadr == TX_ADDR);
   assign empty      = (count == 3'd0);
   assign full       = (count == 3'd4);
   // A pop in the same cycle frees a slot, so a push is never
   // dropped then.
   assign wr         = push && (!full || pop);
   assign last       = (cnt == 8'(CLKS_PER_BIT - 1));
   assign busy       = (state != IDLE) || !empty;
   assign fifo_count = count;

   always_ff @(posedge clk) begin
      if (wr)
         mem[wptr] <= writedata[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rptr     <= 2'd0;
         wptr     <= 2'd0;
         count    <= 3'd0;
         overflow <= 1'b0;
      end else begin
         if (wr)
            wptr <= wptr + 2'd1;
         if (pop)
            rptr <= rptr + 2'd1;
         case ({wr, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
         if (push && !wr)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 8'd0;
         bitn  <= 3'd0;
         shift <= 8'd0;
         tx    <= 1'b1;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         bitn  <= bitn_n;
         shift <= shift_n;
         tx    <= tx_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bitn_n  = bitn;
      shift_n = shift;
      tx_n    = tx;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_n = mem[rptr];
               cnt_n   = 8'd0;
               tx_n    = 1'b0;
               state_n = START;
            end
         end
         START: begin
            if (last) begin
               cnt_n   = 8'd0;
               bitn_n  = 3'd0;
               tx_n    = shift[0];
               state_n = DATA;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         DATA: begin
            if (last) begin
               cnt_n   = 8'd0;
               shift_n = {1'b0, shift[7:1]};
               if (bitn == 3'd7) begin
                  tx_n    = 1'b1;
                  state_n = STOP;
               end else begin
                  bitn_n = bitn + 3'd1;
                  // Next bit is what lands in shift[0] after the shift.
                  tx_n   = shift[1];
               end
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         STOP: begin
            if (last) begin
               cnt_n = 8'd0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_n = mem[rptr];
                  tx_n    = 1'b0;
                  state_n = START;
               end else begin
                  tx_n    = 1'b1;
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: begin
            tx_n    = 1'b1;
            cnt_n   = 8'd0;
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: vector table, directed
// sequences and random stores against a queue/timeline model.
module tb_mmio_uart_tx;

   localparam int          CPB  = 4;
   localparam logic [31:0] ADDR = 32'h0000_00FC;

   logic        clk = 1'b0;
   logic        reset;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic        tx;
   logic        busy;
   logic [2:0]  fifo_count;
   logic        full;
   logic        overflow;

   mmio_uart_tx #(.CLKS_PER_BIT(CPB), .TX_ADDR(ADDR)) dut (
      .clk(clk),
      .reset(reset),
      .memwrite(memwrite),
      .dataadr(dataadr),
      .writedata(writedata),
      .tx(tx),
      .busy(busy),
      .fifo_count(fifo_count),
      .full(full),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: pending bytes, the byte on the wire, its pop edge, and the
   // edge at which its frame ends.
   logic [7:0] q[$];
   logic [7:0] cur = 8'd0;
   int         now = 0;
   int         pop_t = 0;
   int         tx_end = 0;
   bit         ovf_m = 1'b0;

   typedef struct {
      logic        mw;
      logic [31:0] adr;
      logic [31:0] dat;
      int          cnt;
      int          fl;
      int          ovf;
      int          txv;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d expected %0d",
                  nm, now, act, exp);
      end
   endtask

   function automatic int exp_tx();
      int off, b;
      if (now >= tx_end)
         return 1;
      off = now - pop_t;
      b   = off / CPB;
      if (b == 0)
         return 0;
      if (b <= 8)
         return int'(cur[b-1]);
      return 1;
   endfunction

   task automatic model_edge(input bit p, input logic [7:0] d);
      if (q.size() > 0 && now >= tx_end) begin
         cur    = q.pop_front();
         pop_t  = now;
         tx_end = now + 10 * CPB;
      end
      if (p) begin
         if (q.size() < 4)
            q.push_back(d);
         else
            ovf_m = 1'b1;
      end
   endtask

   task automatic check_model();
      chk("tx", int'(tx), exp_tx());
      chk("busy", int'(busy),
          ((now < tx_end) || (q.size() > 0)) ? 1 : 0);
      chk("count", int'(fifo_count), q.size());
      chk("full", int'(full), (q.size() == 4) ? 1 : 0);
      chk("overflow", int'(overflow), int'(ovf_m));
   endtask

   task automatic cyc(input logic mw, input logic [31:0] a,
                      input logic [31:0] d);
      memwrite  = mw;
      dataadr   = a;
      writedata = d;
      @(posedge clk);
      now++;
      model_edge(mw && (a == ADDR), d[7:0]);
      #1;
      check_model();
      memwrite = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b0, 32'h0, 32'h0);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      memwrite = 1'b0;
      #1;
      chk("rst_tx", int'(tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_count", int'(fifo_count), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_ovf", int'(overflow), 0);
      q.delete();
      tx_end = now;
      ovf_m  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'h0000_00F8, 32'h11, 0, 0, 0, 1};
      vecs[1] = '{1'b0, ADDR,          32'h22, 0, 0, 0, 1};
      vecs[2] = '{1'b1, ADDR,          32'hAB01, 1, 0, 0, 1};
      vecs[3] = '{1'b1, ADDR,          32'h02, 1, 0, 0, 0};
      vecs[4] = '{1'b1, ADDR,          32'h03, 2, 0, 0, 0};
      vecs[5] = '{1'b1, ADDR,          32'h04, 3, 0, 0, 0};
      vecs[6] = '{1'b1, ADDR,          32'h05, 4, 1, 0, 0};
      vecs[7] = '{1'b1, ADDR,          32'h06, 4, 1, 1, 1};

      memwrite  = 1'b0;
      dataadr   = 32'h0;
      writedata = 32'h0;
      reset     = 1'b1;
      #2;
      do_reset();

      for (int i = 0; i < 8; i++) begin
         cyc(vecs[i].mw, vecs[i].adr, vecs[i].dat);
         chk("vec_count", int'(fifo_count), vecs[i].cnt);
         chk("vec_full", int'(full), vecs[i].fl);
         chk("vec_ovf", int'(overflow), vecs[i].ovf);
         chk("vec_tx", int'(tx), vecs[i].txv);
      end
      idle(200);
      chk("drain_busy", int'(busy), 0);
      chk("ovf_sticky", int'(overflow), 1);

      do_reset();
      cyc(1'b1, ADDR, 32'h0000_0055);
      for (int i = 0; i < 40; i++) begin
         cyc(1'b0, 32'h0, 32'h0);
         chk("wave55", int'(tx), ((i / CPB) % 2 == 1) ? 1 : 0);
      end
      chk("busy_at_40", int'(busy), 1);
      idle(1);
      chk("busy_after", int'(busy), 0);

      cyc(1'b1, ADDR, 32'h81);
      cyc(1'b1, ADDR, 32'h82);
      cyc(1'b1, ADDR, 32'h83);
      cyc(1'b1, ADDR, 32'h84);
      cyc(1'b1, ADDR, 32'h85);
      chk("pre_full", int'(full), 1);
      for (int i = 0; i < 100 && (now + 1 != tx_end); i++)
         idle(1);
      chk("sync_pop", now + 1, tx_end);
      cyc(1'b1, ADDR, 32'hA5);
      chk("pp_count", int'(fifo_count), 4);
      chk("pp_ovf", int'(overflow), 0);
      idle(5 * 10 * CPB + 5);

      cyc(1'b1, ADDR, 32'h3C);
      cyc(1'b1, ADDR, 32'hC3);
      cyc(1'b1, ADDR, 32'h5A);
      for (int i = 0; i < 40 && (now != pop_t + 13); i++)
         idle(1);
      chk("mid_q", int'(fifo_count), 2);
      do_reset();
      idle(60);
      cyc(1'b1, ADDR, 32'h77);
      chk("first_push", int'(fifo_count), 1);
      idle(45);

      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, ADDR, $urandom);
         idle(44);
      end
      chk("wrap_ovf", int'(overflow), 0);
      idle(10);

      for (int i = 0; i < 600; i++) begin
         logic        mw;
         logic [31:0] a;
         mw = ($urandom_range(0, 9) < 2);
         a  = ($urandom_range(0, 3) == 0) ? $urandom : ADDR;
         cyc(mw, a, $urandom);
      end
      idle(250);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit (legal range 2..255).
REQ-002 Parameter: TX_ADDR, default 32'h0000_00FC, store address that enqueues a byte.
REQ-003 Port: clk  input  1  rising-edge system clock shared with the processor and data memory.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: memwrite  input  1  processor store strobe.
REQ-006 Port: dataadr  input  32  processor store address.
REQ-007 Port: writedata  input  32  processor store data; only bits [7:0] are used.
REQ-008 Port: tx  output  1  serial line, idle high, 8N1 framing.
REQ-009 Port: busy  output  1  high whenever the FSM is not IDLE or the FIFO is non-empty.
REQ-010 Port: fifo_count  output  3  number of queued bytes, 0..4.
REQ-011 Port: full  output  1  high when fifo_count == 4.
REQ-012 Port: overflow  output  1  sticky flag, set when a store is dropped because the FIFO is full.

Function
REQ-013 A push SHALL occur on a rising clk edge where memwrite == 1 and dataadr == TX_ADDR (full 32-bit compare); stores to any other address SHALL be ignored.
REQ-014 The FIFO SHALL be 4 entries x 8 bits, circular, with 2-bit read/write pointers that wrap 3 -> 0.
REQ-015 A push while full with no pop in the same cycle SHALL be dropped, SHALL leave the FIFO contents unchanged, and SHALL set overflow to 1.
REQ-016 A push and a pop in the same cycle SHALL both take effect, leaving fifo_count unchanged; this holds even when the FIFO is full, in which case nothing is dropped.
REQ-017 FSM states SHALL be IDLE, START, DATA, and STOP.
REQ-018 In IDLE with the FIFO non-empty, the FSM SHALL pop the head byte into an 8-bit shift register and enter START on the same edge.
REQ-019 START SHALL drive tx = 0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-020 DATA SHALL drive shift[0] (LSB first) for CLKS_PER_BIT cycles per bit, shifting right after each bit and counting 8 bits with a 3-bit counter, then enter STOP.
REQ-021 STOP SHALL drive tx = 1 for CLKS_PER_BIT cycles.
REQ-022 On leaving STOP, the FSM SHALL enter START directly with a pop if the FIFO is non-empty, and enter IDLE otherwise; there SHALL be no idle gap between back-to-back frames.
REQ-023 A frame SHALL occupy exactly 10*CLKS_PER_BIT cycles.
REQ-024 The bit-period counter SHALL be 8 bits, SHALL count 0..CLKS_PER_BIT-1, and SHALL reset to 0 on every state or bit change.
REQ-025 tx SHALL be driven from a register (glitch-free) and SHALL be 1 in IDLE and STOP.
REQ-026 Latency: a push at edge k into an empty FIFO with the FSM in IDLE SHALL cause a pop at edge k+1, with tx falling at edge k+1.
REQ-027 A byte being shifted SHALL be unaffected by later pushes, and pushes SHALL never corrupt the queued order.
REQ-028 overflow SHALL stay 1 until reset; no other event clears it.

Reset
REQ-029 On reset assertion, asynchronously: state = IDLE, tx = 1, busy = 0, fifo_count = 0, full = 0, overflow = 0, pointers = 0, counters = 0, shift register = 0.
REQ-030 Reset mid-frame SHALL abort the frame immediately with tx = 1, and all queued bytes SHALL be discarded.
REQ-031 After reset deassertion, the first push SHALL be accepted on the first rising edge.

Verification
REQ-032 Store 32'h0000_0055 to TX_ADDR with CLKS_PER_BIT = 4 -> tx waveform 0,1,0,1,0,1,0,1,0,1 per 4-cycle bit (start, LSB-first data, stop); busy drops 40 cycles after the pop.
REQ-033 Store to 32'h0000_00F8 and store with memwrite = 0 at TX_ADDR -> fifo_count stays 0, tx stays 1.
REQ-034 Six back-to-back stores 8'h01..8'h06 while idle -> the first is popped immediately, 8'h02..8'h05 fill the FIFO (full = 1), 8'h06 is dropped with overflow = 1; bytes 01..05 are transmitted contiguously over 200 cycles.
REQ-035 FIFO full while a frame ends (pop) in the same cycle as a push of 8'hA5 -> fifo_count stays 4, overflow stays 0, 8'hA5 is transmitted last.
REQ-036 Assert reset 13 cycles into a frame with 2 bytes queued -> tx = 1 immediately, fifo_count = 0, overflow = 0; no further frames follow.
REQ-037 Pointer wrap: 10 single stores spaced 45 cycles apart -> all 10 bytes are received in order, with no overflow.
